instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_3000, address of first emitted word.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  field set presented.
REQ-006 SHALL have port in_ready  output  1  encoder can accept a field set.
REQ-007 SHALL have port fmt  input  2  00=R, 01=I, 10=J, 11=illegal.
REQ-008 SHALL have ports opcode, funct  input  6 each  instruction fields.
REQ-009 SHALL have ports rs, rt, rd, shamt  input  5 each  instruction fields.
REQ-010 SHALL have ports imm16  input  16 and imm26  input  26  immediates.
REQ-011 SHALL have port out_valid  output  1  out_instr/out_addr hold a word.
REQ-012 SHALL have port out_ready  input  1  consumer takes the word.
REQ-013 SHALL have port out_instr  output  32  encoded instruction word.
REQ-014 SHALL have port out_addr  output  32  address of out_instr.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port err_cnt  output  8  illegal-fmt drop counter.

Function
REQ-017 Accept = in_valid & in_ready at a rising edge; in_ready SHALL equal (count != DEPTH), independent of out_ready.
REQ-018 R format SHALL encode {opcode,rs,rt,rd,shamt,funct}; unused fields ignored.
REQ-019 I format SHALL encode {opcode,rs,rt,imm16}; rd/shamt/funct/imm26 ignored.
REQ-020 J format SHALL encode {opcode,imm26}; all other fields ignored.
REQ-021 fmt=11 SHALL complete the handshake, SHALL NOT enqueue, SHALL increment err_cnt, saturating at 255.
REQ-022 Encoded word SHALL be registered into the FIFO at the accept edge; out_valid SHALL rise in the cycle after the accept when previously empty (1-cycle latency).
REQ-023 out_valid SHALL equal (count != 0); out_instr SHALL show the oldest entry, stable while out_valid & !out_ready.
REQ-024 Pop = out_valid & out_ready at a rising edge; FIFO order strictly first-in first-out.
REQ-025 Address counter SHALL start at BASE_ADDR, drive out_addr, and add 4 on each pop, wrapping modulo 2^32.
REQ-026 Simultaneous legal accept and pop SHALL leave count unchanged and keep order; when full, in_ready=0 so no accept even if popping that cycle.
REQ-027 Simultaneous illegal accept and pop SHALL perform the pop and the err_cnt increment only.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-029 out_instr when out_valid=0 SHALL be don't-care to consumers but SHALL NOT be X after reset (read entry 0, cleared).

Reset
REQ-030 reset=1 SHALL immediately, without clk, force count=0, out_valid=0, in_ready=1, err_cnt=0, out_addr=BASE_ADDR, pointers=0, FIFO storage=0.
REQ-031 Reset asserted mid-transfer SHALL discard all queued words; no accept or pop SHALL occur on an edge where reset=1.
REQ-032 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-033 R: fmt=00, opcode=0, rs=8, rt=9, rd=10, shamt=0, funct=6'h21, out_ready=1 -> next cycle out_valid=1, out_instr=32'h0109_5021, out_addr=32'h0000_3000.
REQ-034 I then J: fmt=01 op=6'h0D rs=0 rt=8 imm16=16'h1234 (-> 32'h3408_1234), then fmt=10 op=6'h02 imm26=26'h0000C00 (-> 32'h0800_0C00); popped words at addresses 0x3000 then 0x3004.
REQ-035 Full: out_ready=0, push 5 legal words with DEPTH=4 -> in_ready=0 after 4th, count=4, 5th held; then out_ready=1 -> words pop in order, 5th accepted once count<4.
REQ-036 Illegal: fmt=11 x300 with in_valid=1 -> count stays 0, out_valid=0, err_cnt=255 (saturated).
REQ-037 Concurrent: count=2, legal push and pop same edge -> count=2, order preserved, out_addr +4.
REQ-038 Async reset: count=3, assert reset between edges -> out_valid=0, count=0, out_addr=32'h0000_3000 before next edge.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction field encoder: packs R/I/J fields into 32-bit words and buffers them
// in a small FIFO, emitting each word with a sequential address.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [15:0]              imm16,
  input  logic [25:0]              imm26,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               err_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Field packing; unused fields of each format are simply not selected.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (fmt_e'(fmt))
      FMT_R:   enc_word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   enc_word = {opcode, rs, rt, imm16};
      FMT_J:   enc_word = {opcode, imm26};
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign pop       = out_valid & out_ready;

  // Next-state for storage, pointers, occupancy, address and error counter.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + 32'd4;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (accept && !enc_legal && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  assign out_instr = mem_q[rd_ptr_q];
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based
// reference model of the encode/FIFO/address/error behaviour.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic [7:0]  err_cnt;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm16     (imm16),
    .imm26     (imm26),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  int          m_err;
  bit          m_last_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    case (fmt)
      2'b00:   return {opcode, rs, rt, rd, shamt, funct};
      2'b01:   return {opcode, rs, rt, imm16};
      default: return {opcode, imm26};
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    m_addr = BASE;
    m_err  = 0;
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("out_addr", out_addr, m_addr);
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    if (mq.size() != 0) check("out_instr", out_instr, mq[0]);
  endtask

  task automatic set_fields(input logic v, input logic [1:0] f);
    in_valid = v;
    fmt      = f;
    opcode   = 6'($urandom);
    funct    = 6'($urandom);
    rs       = 5'($urandom);
    rt       = 5'($urandom);
    rd       = 5'($urandom);
    shamt    = 5'($urandom);
    imm16    = 16'($urandom);
    imm26    = 26'($urandom);
  endtask

  // One clock edge: predict from pre-edge inputs, then compare after the edge.
  task automatic tick();
    bit acc, pop, legal;
    logic [31:0] w;
    acc   = in_valid && !reset && (mq.size() < DEPTH);
    pop   = out_ready && !reset && (mq.size() > 0);
    legal = (fmt != 2'b11);
    w     = model_word();
    @(posedge clk);
    #1;
    m_last_acc = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc && legal) begin
        mq.push_back(w);
        m_last_acc = 1'b1;
      end
      if (acc && !legal && m_err < 255) m_err++;
    end
    check_outputs();
  endtask

  // Called at posedge+1; asserts reset between edges, holds it over one edge
  // with live stimulus, releases between edges (returns at posedge+3).
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    check("rst_async_addr", out_addr, BASE);
    check("rst_async_ready", 32'(in_ready), 32'd1);
    set_fields(1'b1, 2'b00);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge_noacc", 32'(count), 32'd0);
    check("rst_edge_err", 32'(err_cnt), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    set_fields(1'b0, 2'b00);
    model_clear();
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_err", 32'(err_cnt), 32'd0);
    check("reset_addr", out_addr, BASE);
    check("reset_instr", out_instr, 32'd0);
    #2;
    reset = 1'b0;

    // R-format word, first edge after reset
    set_fields(1'b1, 2'b00);
    opcode = 6'h00; rs = 5'd8; rt = 5'd9; rd = 5'd10; shamt = 5'd0; funct = 6'h21;
    out_ready = 1'b1;
    tick();
    check("r_valid", 32'(out_valid), 32'd1);
    check("r_instr", out_instr, 32'h0109_5021);
    check("r_addr", out_addr, 32'h0000_3000);
    in_valid = 1'b0;
    tick();

    // I then J, popped in order at consecutive addresses
    do_reset();
    out_ready = 1'b0;
    set_fields(1'b1, 2'b01);
    opcode = 6'h0D; rs = 5'd0; rt = 5'd8; imm16 = 16'h1234;
    tick();
    set_fields(1'b1, 2'b10);
    opcode = 6'h02; imm26 = 26'h0000C00;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("i_instr", out_instr, 32'h3408_1234);
    check("i_addr", out_addr, 32'h0000_3000);
    tick();
    check("j_instr", out_instr, 32'h0800_0C00);
    check("j_addr", out_addr, 32'h0000_3004);
    tick();

    // Fill to full, hold fifth word, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fields(1'b1, 2'($urandom_range(0, 2)));
      tick();
      if (i == 3) begin
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
      end
    end
    tick();
    check("full_held", 32'(count), 32'd4);
    out_ready  = 1'b1;
    m_last_acc = 1'b0;
    for (int k = 0; k < 8 && !m_last_acc; k++) tick();
    check("fifth_accepted", 32'(m_last_acc), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Illegal format saturates the error counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_fields(1'b1, 2'b11);
      out_ready = 1'($urandom);
      tick();
    end
    check("illegal_err_sat", 32'(err_cnt), 32'd255);
    check("illegal_count", 32'(count), 32'd0);

    // Concurrent push and pop at count=2
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_fields(1'b1, 2'b00);
      tick();
    end
    set_fields(1'b1, 2'b01);
    out_ready = 1'b1;
    tick();
    check("conc_count", 32'(count), 32'd2);
    check("conc_addr", out_addr, 32'h0000_3004);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Async reset with three queued words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fields(1'b1, 2'($urandom_range(0, 2)));
      tick();
    end
    check("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    do_reset();
    set_fields(1'b1, 2'b10);
    out_ready = 1'b0;
    tick();
    check("post_rst_accept", 32'(count), 32'd1);

    // Random traffic with occasional illegal formats and resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      set_fields(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
